// File: rtl/id_reg_file_sb.sv
// Decode-stage register file with two bypassed read ports, NUM_WB write-back ports
// and a saturating per-register pending-write scoreboard.
module id_reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_WB     = 2,
    parameter int CNT_WIDTH  = 3,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AW-1:0]                rs1_addr,
    output logic [DATA_WIDTH-1:0]        rs1_data,
    output logic                         rs1_busy,
    input  logic [AW-1:0]                rs2_addr,
    output logic [DATA_WIDTH-1:0]        rs2_data,
    output logic                         rs2_busy,
    input  logic                         alloc_valid,
    input  logic [AW-1:0]                alloc_rd,
    output logic                         alloc_ready,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*AW-1:0]         wb_rd,
    input  logic [NUM_WB*DATA_WIDTH-1:0] wb_data,
    output logic                         pending_any,
    output logic                         err_underflow
);

    // Widened arithmetic width: holds cnt + alloc - hits for NUM_WB <= 4 without wrap.
    localparam int SW = CNT_WIDTH + 3;

    logic [DATA_WIDTH-1:0] regs    [NUM_REGS];
    logic [CNT_WIDTH-1:0]  cnt     [NUM_REGS];
    logic [SW-1:0]         hits    [NUM_REGS];
    logic                  wr_en   [NUM_REGS];
    logic [DATA_WIDTH-1:0] wr_val  [NUM_REGS];
    logic [CNT_WIDTH-1:0]  cnt_nxt [NUM_REGS];
    logic [SW-1:0]         sum;
    logic                  alloc_acc;
    logic                  uf_any;

    // Ascending port scan makes the highest-index hitting port win.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            hits[r]   = '0;
            wr_en[r]  = 1'b0;
            wr_val[r] = regs[r];
            for (int unsigned p = 0; p < NUM_WB; p++) begin
                if (r != 0 && wb_valid[p] && wb_rd[p*AW +: AW] == AW'(r)) begin
                    hits[r]   = hits[r] + SW'(1);
                    wr_en[r]  = 1'b1;
                    wr_val[r] = wb_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        alloc_ready = (alloc_rd == '0) || (cnt[alloc_rd] != '1);
        alloc_acc   = alloc_valid && alloc_ready && (alloc_rd != '0);
        uf_any      = 1'b0;
        sum         = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            sum = {3'b000, cnt[r]} + SW'(alloc_acc && alloc_rd == AW'(r));
            if (sum < hits[r]) begin
                cnt_nxt[r] = '0;
                uf_any     = 1'b1;
            end else begin
                cnt_nxt[r] = CNT_WIDTH'(sum - hits[r]);
            end
        end
    end

    always_comb begin
        pending_any = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (cnt[r] != '0) pending_any = 1'b1;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : wr_val[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : wr_val[rs2_addr];
        rs1_busy = {3'b000, cnt[rs1_addr]} > hits[rs1_addr];
        rs2_busy = {3'b000, cnt[rs2_addr]} > hits[rs2_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (wr_en[r]) regs[r] <= wr_val[r];
                cnt[r] <= cnt_nxt[r];
            end
            if (uf_any) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_reg_file_sb.sv
// Directed bench for id_reg_file_sb: reset, bypass, saturation, multi-port
// write-back, underflow, register 0 and mid-operation reset.
module tb_id_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1_addr, rs2_addr, alloc_rd;
    logic [DW-1:0] rs1_data, rs2_data;
    logic          rs1_busy, rs2_busy, alloc_valid, alloc_ready;
    logic [1:0]    wb_valid;
    logic [2*AW-1:0] wb_rd;
    logic [2*DW-1:0] wb_data;
    logic          pending_any, err_underflow;

    int compared   = 0;
    int mismatched = 0;

    id_reg_file_sb #(
        .DATA_WIDTH(32),
        .NUM_REGS(32),
        .NUM_WB(2),
        .CNT_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .pending_any(pending_any), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic [1:0] v, input logic [AW-1:0] rd0, input logic [DW-1:0] d0,
                          input logic [AW-1:0] rd1, input logic [DW-1:0] d1);
        wb_valid = v;
        wb_rd    = {rd1, rd0};
        wb_data  = {d1, d0};
    endtask

    initial begin
        rst = 1'b1; rs1_addr = '0; rs2_addr = '0; alloc_valid = 1'b0; alloc_rd = '0;
        set_wb(2'b00, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;

        // reset state
        rs1_addr = 5; #1;
        chk("rst_data", rs1_data, 0);
        chk("rst_busy", rs1_busy, 0);
        chk("rst_pend", pending_any, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_ready", alloc_ready, 1);

        // alloc x3 is not visible in the same cycle
        alloc_valid = 1'b1; alloc_rd = 3; rs1_addr = 3; #1;
        chk("x3_alloc_same_cyc", rs1_busy, 0);
        tick();
        alloc_valid = 1'b0; #1;
        chk("x3_busy", rs1_busy, 1);
        chk("x3_pend", pending_any, 1);
        set_wb(2'b01, 3, 32'hDEADBEEF, 0, 0); #1;
        chk("x3_bypass_data", rs1_data, 32'hDEADBEEF);
        chk("x3_bypass_busy", rs1_busy, 0);
        tick();
        set_wb(2'b00, 0, 0, 0, 0); #1;
        chk("x3_stored", rs1_data, 32'hDEADBEEF);
        chk("x3_pend_clr", pending_any, 0);

        // saturate x7
        alloc_valid = 1'b1; alloc_rd = 7; rs2_addr = 7;
        for (int i = 0; i < 7; i++) tick();
        #1;
        chk("x7_full_ready", alloc_ready, 0);
        tick();   // 8th attempt, refused
        set_wb(2'b10, 0, 0, 7, 32'h77); #1;
        chk("x7_full_wb_ready", alloc_ready, 0);
        tick();
        alloc_valid = 1'b0; set_wb(2'b00, 0, 0, 0, 0); #1;
        chk("x7_ready_after_wb", alloc_ready, 1);
        chk("x7_busy_6", rs2_busy, 1);
        chk("x7_data", rs2_data, 32'h77);
        set_wb(2'b01, 7, 32'h70, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("x7_last_wb_busy", rs2_busy, 0);
        tick();
        set_wb(2'b00, 0, 0, 0, 0); #1;
        chk("x7_drained_pend", pending_any, 0);
        chk("x7_drained_err", err_underflow, 0);

        // two ports hit x4 in one cycle
        alloc_valid = 1'b1; alloc_rd = 4; rs1_addr = 4;
        tick(); tick();
        alloc_valid = 1'b0;
        set_wb(2'b11, 4, 32'h11, 4, 32'h22); #1;
        chk("x4_bypass_hi", rs1_data, 32'h22);
        chk("x4_bypass_busy", rs1_busy, 0);
        tick();
        set_wb(2'b00, 0, 0, 0, 0); #1;
        chk("x4_stored", rs1_data, 32'h22);
        chk("x4_busy", rs1_busy, 0);
        chk("x4_pend", pending_any, 0);

        // alloc and write-back to x4 in the same cycle net out
        alloc_valid = 1'b1; tick();
        set_wb(2'b01, 4, 32'h44, 0, 0); tick();
        alloc_valid = 1'b0; set_wb(2'b00, 0, 0, 0, 0); #1;
        chk("x4_net_busy", rs1_busy, 1);
        chk("x4_net_data", rs1_data, 32'h44);
        chk("x4_net_err", err_underflow, 0);
        set_wb(2'b01, 4, 32'h45, 0, 0); tick();
        set_wb(2'b00, 0, 0, 0, 0); #1;
        chk("x4_net_pend", pending_any, 0);

        // register 0 ignores alloc and write-back
        alloc_valid = 1'b1; alloc_rd = 0; rs1_addr = 0;
        set_wb(2'b01, 0, 32'hFFFF, 0, 0); #1;
        chk("x0_ready", alloc_ready, 1);
        chk("x0_bypass", rs1_data, 0);
        chk("x0_busy", rs1_busy, 0);
        tick();
        alloc_valid = 1'b0; set_wb(2'b00, 0, 0, 0, 0); #1;
        chk("x0_data", rs1_data, 0);
        chk("x0_pend", pending_any, 0);
        chk("x0_err", err_underflow, 0);

        // write-back to x9 with nothing pending
        rs1_addr = 9;
        set_wb(2'b01, 9, 32'h99, 0, 0); tick();
        set_wb(2'b00, 0, 0, 0, 0); #1;
        chk("x9_err", err_underflow, 1);
        chk("x9_data", rs1_data, 32'h99);
        chk("x9_busy", rs1_busy, 0);
        chk("x9_pend", pending_any, 0);
        alloc_rd = 9; #1;
        chk("x9_ready", alloc_ready, 1);
        tick(); tick();
        chk("x9_err_sticky", err_underflow, 1);

        // reset while x2 has three pending writes
        alloc_valid = 1'b1; alloc_rd = 2; rs1_addr = 2;
        for (int i = 0; i < 4; i++) tick();
        alloc_valid = 1'b0;
        set_wb(2'b01, 2, 32'h2222, 0, 0); tick();
        set_wb(2'b00, 0, 0, 0, 0); #1;
        chk("x2_pre_data", rs1_data, 32'h2222);
        chk("x2_pre_busy", rs1_busy, 1);
        rst = 1'b1; alloc_valid = 1'b1;
        set_wb(2'b01, 2, 32'h5555, 0, 0); tick();
        rst = 1'b0; alloc_valid = 1'b0; set_wb(2'b00, 0, 0, 0, 0); #1;
        chk("x2_rst_data", rs1_data, 0);
        chk("x2_rst_busy", rs1_busy, 0);
        chk("x2_rst_pend", pending_any, 0);
        chk("x2_rst_err", err_underflow, 0);
        chk("x2_rst_ready", alloc_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/id_reg_file_sb.md
Name: id_reg_file_sb

Overview:
- Parametrised decode-stage register file with a per-register pending-write scoreboard.
- Serves two combinational read ports with same-cycle write-back bypass.
- Accepts NUM_WB concurrent write-back ports.
- Tracks outstanding in-flight writes per register with saturating counters, so issue logic can stall on hazards and on counter overflow.

Parameters:
- DATA_WIDTH, 32, register data width in bits.
- NUM_REGS, 32, architectural register count; register 0 is hardwired zero; must be a power of two >= 2.
- NUM_WB, 2, number of independent write-back ports (1..4).
- CNT_WIDTH, 3, width of each pending-write counter; maximum outstanding writes per register = 2^CNT_WIDTH - 1.
- Derived localparam AW = clog2(NUM_REGS).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- rs1_addr  input  AW  read port 1 address.
- rs1_data  output  DATA_WIDTH  read port 1 data (combinational).
- rs1_busy  output  1  register rs1 still has pending writes after this cycle's write-backs.
- rs2_addr  input  AW  read port 2 address.
- rs2_data  output  DATA_WIDTH  read port 2 data.
- rs2_busy  output  1  as rs1_busy, for rs2.
- alloc_valid  input  1  issue stage requests to mark alloc_rd as pending.
- alloc_rd  input  AW  destination register being allocated.
- alloc_ready  output  1  allocation for alloc_rd can be accepted this cycle.
- wb_valid  input  NUM_WB  per-port write-back strobe.
- wb_rd  input  NUM_WB*AW  per-port destination; port i occupies bits [i*AW +: AW].
- wb_data  input  NUM_WB*DATA_WIDTH  per-port data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- pending_any  output  1  at least one counter is nonzero (registered state).
- err_underflow  output  1  sticky: a write-back arrived for a register with no pending write.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - All registers become 0, all counters become 0, err_underflow becomes 0.
  - Reset overrides any same-cycle alloc or write-back.
  - Reset mid-operation discards all in-flight tracking.
  - After reset: rs*_data=0, rs*_busy=0, pending_any=0, alloc_ready=1.
- Register 0:
  - Reads return 0 with busy=0.
  - Write-backs to 0 are ignored: no data change, no counter change, no error.
  - alloc with alloc_rd=0 is ignored and alloc_ready=1.
- Write-back hit definition: port i hits register r when wb_valid[i]=1, wb_rd_i=r and r!=0; hits(r) = number of hitting ports.
- Data write:
  - At posedge, each hit register takes the wb_data of its highest-index hitting port.
  - Multiple ports writing the same register is legal: highest index wins.
- Read and bypass:
  - rsN_data = 0 if rsN_addr=0.
  - Otherwise it is the wb_data of the highest-index port hitting rsN_addr this cycle, else the stored value.
  - Zero-cycle latency.
- Busy: rsN_busy = (cnt[rsN_addr] - hits(rsN_addr)) > 0, evaluated without wrap.
  - A same-cycle alloc does NOT raise busy in the same cycle; it is visible from the next cycle.
- Allocation:
  - alloc_ready = (alloc_rd==0) or (cnt[alloc_rd] != 2^CNT_WIDTH-1); purely combinational and independent of alloc_valid.
  - Accepted when alloc_valid & alloc_ready & alloc_rd!=0.
  - At max count, alloc_ready=0 even if a write-back to that register occurs in the same cycle (conservative stall).
- Counter update per register r at posedge: next = cnt + accepted_alloc(r) - hits(r).
  - If the result would be < 0: cnt becomes 0 and err_underflow is set to 1.
  - err_underflow stays 1 until reset.
  - Alloc and write-back to the same register in the same cycle net out.
- pending_any: OR of all counters != 0, reflecting current registered state.
- All arithmetic is done at CNT_WIDTH+3 bits before clamping, so no wrap occurs for NUM_WB <= 4.

Test Plan:
- Reset, then read x5 with rs1_addr=5 -> rs1_data=0, rs1_busy=0, pending_any=0, err_underflow=0.
- Alloc x3; next cycle rs1_addr=3 -> busy=1. wb port0 x3=0xDEADBEEF that cycle -> rs1_data=0xDEADBEEF, busy=0 (bypass). Next cycle stored value holds and pending_any=0.
- Alloc x7 seven times (CNT_WIDTH=3) -> alloc_ready=0 on the 8th attempt, and the counter stays at 7. One wb to x7 -> alloc_ready=1 the following cycle.
- Alloc x4 twice, then wb port0 and port1 both to x4 in the same cycle with data 0x11 and 0x22 -> stored value 0x22, counter 0, busy=0.
- wb x9 with no prior alloc -> err_underflow=1 and stays high; x9 data still written; counter stays 0.
- alloc x0 and wb x0=0xFFFF -> x0 reads 0, busy=0, no error. Assert rst while x2 has pending=3 -> next cycle counter 0, data 0, err_underflow=0.
